ipsxe_floating_point_fixed_to_float_v1_0: RTL and testbench

IPSXE_FLOATING_POINT_FIXED_TO_FLOAT_V1_0 -- requirements
Module: ipsxe_floating_point_fixed_to_float_v1_0

---
 rtl/ipsxe_floating_point_pkg.sv | 23 ++
 rtl/ipsxe_floating_point_lzc_v1_0.sv | 21 ++
 rtl/ipsxe_floating_point_fixed_to_float_v1_0.sv | 162 ++++++++++++++++
 tb/tb_ipsxe_floating_point_fixed_to_float_v1_0.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_floating_point_pkg.sv
// Shared floating-point constants and helpers for the fixed<->float converter family.
// Width, bias and all-ones exponent derivations live here so every converter agrees on them.
package ipsxe_floating_point_pkg;

  typedef struct packed {
    logic inexact;
    logic overflow;
    logic underflow;
  } fp_flags_t;

  function automatic int fixed_width(input int int_bit, input int frac_bit);
    return int_bit + frac_bit;
  endfunction

  function automatic int exp_bias(input int exp_bit);
    return (1 << (exp_bit - 1)) - 1;
  endfunction

  function automatic int exp_all_ones(input int exp_bit);
    return (1 << exp_bit) - 1;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_lzc_v1_0.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module ipsxe_floating_point_lzc_v1_0 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  // Scanning upward lets the highest set bit win without a found flag.
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/ipsxe_floating_point_fixed_to_float_v1_0.sv
// Three-stage two's-complement fixed-point to IEEE-style float converter:
// magnitude -> normalize -> round-to-nearest-even, with AXI4-Stream style handshake.
module ipsxe_floating_point_fixed_to_float_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int FIXED_INT_BIT  = 32,
  parameter int FIXED_FRAC_BIT = 0,
  parameter int FLOAT_EXP_BIT  = 8,
  parameter int FLOAT_FRAC_BIT = 24
) (
  input  logic                                                 i_aclk,
  input  logic                                                 i_areset,
  input  logic                                                 i_aclken,
  input  logic [fixed_width(FIXED_INT_BIT, FIXED_FRAC_BIT)-1:0] i_axi4s_a_tdata,
  input  logic                                                 i_axi4s_a_tvalid,
  output logic                                                 o_axi4s_a_tready,
  output logic [FLOAT_EXP_BIT+FLOAT_FRAC_BIT-1:0]              o_axi4s_result_tdata,
  output logic                                                 o_axi4s_result_tvalid,
  input  logic                                                 i_m_axis_result_tready,
  output logic                                                 o_inexact,
  output logic                                                 o_overflow,
  output logic                                                 o_underflow
);

  localparam int W    = fixed_width(FIXED_INT_BIT, FIXED_FRAC_BIT);
  localparam int M    = FLOAT_FRAC_BIT;
  localparam int EW   = FLOAT_EXP_BIT;
  localparam int RW   = EW + M;
  localparam int LZW  = $clog2(W + 1);
  localparam int XW   = W + M;
  localparam int SEW  = EW + LZW + 2;
  localparam int EOFF = W - 1 - FIXED_FRAC_BIT + exp_bias(EW);
  localparam logic signed [SEW-1:0] EMAX = SEW'(exp_all_ones(EW));

  logic                  en;
  logic                  s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic [W-1:0]          s1_mag_q, s1_mag_d;
  logic                  s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  logic                  s2_zero_q, s2_zero_d;
  logic [W-2:0]          s2_frac_q, s2_frac_d;
  logic signed [SEW-1:0] s2_exp_q, s2_exp_d;
  logic                  out_valid_q, out_valid_d;
  logic [RW-1:0]         out_data_q, out_data_d;
  fp_flags_t             out_flags_q, out_flags_d;

  logic [LZW-1:0]        lz;
  logic                  mag_zero;
  logic [XW-1:0]         ext;
  logic                  guard, sticky, rnd_up, carry;
  logic [M-1:0]          frac_sum;
  logic signed [SEW-1:0] e_rnd;
  logic [RW-1:0]         res_data;
  fp_flags_t             res_flags;

  assign en = i_aclken && (!out_valid_q || i_m_axis_result_tready);
  assign o_axi4s_a_tready = en;

  // NOTE: every always_comb output is first given its held value, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (en) begin
      s1_valid_d = i_axi4s_a_tvalid;
      s1_sign_d  = i_axi4s_a_tdata[W-1];
      s1_mag_d   = i_axi4s_a_tdata[W-1] ? (~i_axi4s_a_tdata) + W'(1) : i_axi4s_a_tdata;
    end
  end

  ipsxe_floating_point_lzc_v1_0 #(.WIDTH(W), .CNT_W(LZW)) u_lzc (
    .i_data  (s1_mag_q),
    .o_count (lz),
    .o_zero  (mag_zero)
  );

  // The leading one is implicit after normalization, so only the bits below it are kept.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_frac_d  = s2_frac_q;
    s2_exp_d   = s2_exp_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = mag_zero;
      s2_frac_d  = (W-1)'(s1_mag_q << lz);
      s2_exp_d   = SEW'(EOFF) - SEW'(lz);
    end
  end

  always_comb begin
    ext      = {s2_frac_q, {(M + 1){1'b0}}};
    guard    = ext[XW-M];
    sticky   = |ext[XW-M-1:0];
    rnd_up   = guard & (sticky | ext[XW-M+1]);
    frac_sum = {1'b0, ext[XW-1 -: M-1]} + M'(rnd_up);
    carry    = frac_sum[M-1];
    e_rnd    = s2_exp_q + SEW'(carry);

    res_data  = {s2_sign_q, e_rnd[EW-1:0], frac_sum[M-2:0]};
    res_flags = '{inexact: guard | sticky, overflow: 1'b0, underflow: 1'b0};
    if (s2_zero_q) begin
      res_data  = '0;
      res_flags = '0;
    end else if (e_rnd >= EMAX) begin
      res_data           = {s2_sign_q, {EW{1'b1}}, {(M - 1){1'b0}}};
      res_flags.overflow = 1'b1;
    end else if (e_rnd[SEW-1] || e_rnd == '0) begin
      res_data            = {s2_sign_q, {(RW - 1){1'b0}}};
      res_flags.underflow = 1'b1;
      res_flags.inexact   = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_data_d  = s2_valid_q ? res_data : '0;
      out_flags_d = s2_valid_q ? res_flags : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values of the one before.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_frac_q   <= '0;
      s2_exp_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_frac_q   <= s2_frac_d;
      s2_exp_q    <= s2_exp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign o_axi4s_result_tdata  = out_data_q;
  assign o_axi4s_result_tvalid = out_valid_q;
  assign o_inexact             = out_flags_q.inexact;
  assign o_overflow            = out_flags_q.overflow;
  assign o_underflow           = out_flags_q.underflow;

endmodule

// File: tb/tb_ipsxe_floating_point_fixed_to_float_v1_0.sv
// Self-checking bench for the default 32-bit integer to single-precision converter;
// a scoreboard of arithmetic reference results tracks every accepted operand.
module tb_ipsxe_floating_point_fixed_to_float_v1_0;

  logic        clk = 1'b0;
  logic        rst;
  logic        aclken;
  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic        m_tready;
  logic        inexact, overflow, underflow;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t exp_q[$];

  ipsxe_floating_point_fixed_to_float_v1_0 dut (
    .i_aclk                 (clk),
    .i_areset               (rst),
    .i_aclken               (aclken),
    .i_axi4s_a_tdata        (a_tdata),
    .i_axi4s_a_tvalid       (a_tvalid),
    .o_axi4s_a_tready       (a_tready),
    .o_axi4s_result_tdata   (r_tdata),
    .o_axi4s_result_tvalid  (r_tvalid),
    .i_m_axis_result_tready (m_tready),
    .o_inexact              (inexact),
    .o_overflow             (overflow),
    .o_underflow            (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference conversion written with integer arithmetic: find the top bit, shift, round half to even.
  function automatic exp_t model(input logic [31:0] x);
    exp_t   r;
    logic   sign;
    longint mag, kept, rem, half;
    int     p, e, shift;
    sign    = x[31];
    mag     = sign ? (64'sd4294967296 - longint'(x)) : longint'(x);
    r.flags = 3'b000;
    r.data  = 32'h0;
    if (mag == 0) return r;
    p = 0;
    for (int i = 0; i < 33; i++) if (mag[i]) p = i;
    e = p + 127;
    if (p <= 23) begin
      kept = mag << (23 - p);
    end else begin
      shift = p - 23;
      kept  = mag >> shift;
      rem   = mag - (kept << shift);
      half  = longint'(1) << (shift - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (rem != 0) r.flags[2] = 1'b1;
      if (kept == (longint'(1) << 24)) begin
        kept = kept >> 1;
        e    = e + 1;
      end
    end
    r.data = {sign, 8'(e), 23'(kept)};
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  // One clock: score any result handed off this cycle, log any operand accepted, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (r_tvalid && m_tready && aclken) begin
      check("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_tdata", r_tdata, e.data);
        check("sb_flags", {inexact, overflow, underflow}, e.flags);
      end
    end
    if (a_tready && a_tvalid) exp_q.push_back(model(a_tdata));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] want,
                        input logic want_inex);
    a_tdata  = x;
    a_tvalid = 1'b1;
    check({tag, "_accept"}, a_tready, 1'b1);
    tick();
    a_tvalid = 1'b0;
    check({tag, "_lat1"}, r_tvalid, 1'b0);
    tick();
    check({tag, "_lat2"}, r_tvalid, 1'b0);
    tick();
    check({tag, "_lat3"}, r_tvalid, 1'b1);
    check({tag, "_tdata"}, r_tdata, want);
    check({tag, "_inexact"}, inexact, want_inex);
    tick();
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    x = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) x = -x;
    return x;
  endfunction

  initial begin
    logic [31:0] held, snap_data;
    logic [2:0]  snap_flags;
    logic [31:0] ops[8];
    int          sent, cyc;
    logic        accepted;

    // Reset applies even with the clock enable low and operands offered.
    rst      = 1'b1;
    aclken   = 1'b0;
    a_tvalid = 1'b1;
    a_tdata  = 32'h1234_5678;
    m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", r_tvalid, 1'b0);
    check("rst_tdata", r_tdata, 32'h0);
    check("rst_flags", {inexact, overflow, underflow}, 3'b000);
    rst      = 1'b0;
    aclken   = 1'b1;
    a_tvalid = 1'b0;
    #1;
    check("rst_release_tready", a_tready, 1'b1);

    single("one",     32'h0000_0001, 32'h3F80_0000, 1'b0);
    single("neg_one", 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
    single("min_neg", 32'h8000_0000, 32'hCF00_0000, 1'b0);
    single("max_pos", 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1);
    single("tie_dn",  32'h0100_0001, 32'h4B80_0000, 1'b1);
    single("tie_up",  32'h0100_0003, 32'h4B80_0002, 1'b1);
    single("zero",    32'h0000_0000, 32'h0000_0000, 1'b0);
    check("zero_ovf_unf", {overflow, underflow}, 2'b00);

    // Back-to-back throughput with downstream always ready.
    for (int i = 0; i < 20; i++) begin
      a_tdata  = rand_operand();
      a_tvalid = 1'b1;
      tick();
    end
    a_tvalid = 1'b0;
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 80; i++) begin
      a_tdata  = rand_operand();
      a_tvalid = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 3) != 0);
      tick();
    end
    a_tvalid = 1'b0;
    m_tready = 1'b1;
    drain();

    // Eight operands with downstream stalled for five cycles mid-stream.
    for (int i = 0; i < 8; i++) ops[i] = rand_operand();
    sent = 0;
    cyc  = 0;
    held = 32'h0;
    while (sent < 8 && cyc < 100) begin
      a_tdata  = ops[sent];
      a_tvalid = 1'b1;
      m_tready = !(cyc >= 4 && cyc < 9);
      #1;
      accepted = a_tready;
      if (!m_tready) begin
        check("stall_tvalid", r_tvalid, 1'b1);
        check("stall_tready_low", a_tready, 1'b0);
        if (cyc > 4) check("stall_tdata_hold", r_tdata, held);
        held = r_tdata;
      end
      tick();
      if (accepted) sent++;
      cyc++;
    end
    check("stall_all_sent", sent, 8);
    a_tvalid = 1'b0;
    m_tready = 1'b1;
    drain();

    // Reset with two operands in flight: nothing stale may come out afterwards.
    a_tdata  = 32'h0000_0005;
    a_tvalid = 1'b1;
    tick();
    a_tdata  = 32'h0000_0007;
    tick();
    a_tvalid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tvalid", r_tvalid, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("midrst_release_tready", a_tready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_stale", r_tvalid, 1'b0);
      tick();
    end
    single("post_rst", 32'hFFFF_FFFE, 32'hC000_0000, 1'b0);

    // Clock enable low for three cycles with a valid result waiting: everything freezes.
    for (int i = 0; i < 3; i++) begin
      a_tdata  = rand_operand();
      a_tvalid = 1'b1;
      tick();
    end
    check("freeze_pre_tvalid", r_tvalid, 1'b1);
    snap_data  = r_tdata;
    snap_flags = {inexact, overflow, underflow};
    aclken     = 1'b0;
    a_tdata    = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("freeze_tready", a_tready, 1'b0);
      tick();
      check("freeze_tvalid", r_tvalid, 1'b1);
      check("freeze_tdata", r_tdata, snap_data);
      check("freeze_flags", {inexact, overflow, underflow}, snap_flags);
    end
    aclken   = 1'b1;
    a_tvalid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
